// File: rtl/pour_pkg.sv
// Shared types and defaults for the pour sequencer.
// Optional timeout supervision is enabled by defining SEQ_TIMEOUT_EN.
package pour_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_ACK,
        ST_DONE,
        ST_ERR
    } pour_state_t;

    localparam int unsigned POUR_UNIT_W      = 8;
    localparam int unsigned POUR_TIMEOUT_CYC = 1000;
    localparam int unsigned POUR_TMO_W       = 10;

endpackage

// File: rtl/pour_seq_tmo.sv
// RUN-state watchdog: counts enabled cycles since the last clear and flags
// the last permitted cycle. Only instantiated when SEQ_TIMEOUT_EN is defined.
module pour_seq_tmo #(
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned TMO_W       = 10
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + TMO_W'(1);
        end
    end

    // Count starts at 0 in the first RUN cycle, so this marks the
    // TIMEOUT_CYC-th RUN cycle; the FSM leaves on the following edge.
    assign o_expired = (r_cnt == TMO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/pour_seq.sv
// Pour-order sequencer for one emitter channel: loads/enables the emitter and
// counts count2/count_ACK2 handshakes. SEQ_TIMEOUT_EN adds RUN-state timeout.
module pour_seq
    import pour_pkg::*;
#(
    parameter int unsigned UNIT_W      = POUR_UNIT_W,
    parameter int unsigned TIMEOUT_CYC = POUR_TIMEOUT_CYC,
    parameter int unsigned TMO_W       = POUR_TMO_W
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              order_valid,
    output logic              order_ready,
    input  logic [UNIT_W-1:0] order_units,
    output logic              load2,
    output logic              out_ctrl,
    input  logic              count2,
    output logic              count_ACK2,
    output logic [UNIT_W-1:0] units_done,
    output logic              busy,
    output logic              done,
    output logic              err
);

    pour_state_t       r_state;
    pour_state_t       w_next;
    logic              w_accept;
    logic              w_tmo_expired;
    logic [UNIT_W-1:0] r_target;
    logic [UNIT_W-1:0] r_units_done;
    logic              r_order_ready;
    logic              r_load2;
    logic              r_out_ctrl;
    logic              r_count_ack2;
    logic              r_busy;
    logic              r_done;

    assign w_accept = order_valid & r_order_ready;

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = (order_units == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: w_next = ST_RUN;
            ST_RUN: begin
                if (count2) begin
                    w_next = ST_ACK;
                end else if (w_tmo_expired) begin
                    w_next = ST_ERR;
                end
            end
            ST_ACK: begin
                if (!count2) begin
                    w_next = (r_units_done == r_target) ? ST_DONE : ST_RUN;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            ST_ERR:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs are registered decodes of the next state, so each one changes
    // on the same edge as the state transition that implies it.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_order_ready <= 1'b0;
            r_load2       <= 1'b0;
            r_out_ctrl    <= 1'b0;
            r_count_ack2  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_target      <= '0;
            r_units_done  <= '0;
        end else begin
            r_order_ready <= (w_next == ST_IDLE);
            r_load2       <= (w_next == ST_LOAD);
            r_out_ctrl    <= (w_next == ST_RUN) || (w_next == ST_ACK);
            r_count_ack2  <= (w_next == ST_ACK);
            r_busy        <= (w_next == ST_LOAD) || (w_next == ST_RUN) ||
                             (w_next == ST_ACK);
            r_done        <= (w_next == ST_DONE);
            if (w_accept) begin
                r_target     <= order_units;
                r_units_done <= '0;
            end else if ((r_state == ST_RUN) && count2) begin
                r_units_done <= r_units_done + UNIT_W'(1);
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    logic r_err;

    pour_seq_tmo #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TMO_W       (TMO_W)
    ) u_tmo (
        .i_clk     (clk),
        .i_rst_n   (RESET),
        .i_clear   (r_state != ST_RUN),
        .i_enable  (r_state == ST_RUN),
        .o_expired (w_tmo_expired)
    );

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_next == ST_ERR) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_tmo_expired = 1'b0;
    assign err           = 1'b0;
`endif

    assign order_ready = r_order_ready;
    assign load2       = r_load2;
    assign out_ctrl    = r_out_ctrl;
    assign count_ACK2  = r_count_ack2;
    assign units_done  = r_units_done;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_pour_seq.sv
// Scoreboard bench for pour_seq: order targets are queued on issue and
// checked against units_done at each done pulse.
module tb_pour_seq;

    localparam int unsigned UNIT_W = 8;

    logic              clk = 1'b0;
    logic              RESET;
    logic              order_valid;
    logic              order_ready;
    logic [UNIT_W-1:0] order_units;
    logic              load2;
    logic              out_ctrl;
    logic              count2;
    logic              count_ACK2;
    logic [UNIT_W-1:0] units_done;
    logic              busy;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_err    = 0;
    int sb[$];
    int exp_units;
    int n_load_cyc, n_oc_cyc, n_ack_rise, n_done_cyc;
    logic prev_ack = 1'b0;

    pour_seq #(
        .UNIT_W      (UNIT_W),
        .TIMEOUT_CYC (20),
        .TMO_W       (10)
    ) dut (
        .clk         (clk),
        .RESET       (RESET),
        .order_valid (order_valid),
        .order_ready (order_ready),
        .order_units (order_units),
        .load2       (load2),
        .out_ctrl    (out_ctrl),
        .count2      (count2),
        .count_ACK2  (count_ACK2),
        .units_done  (units_done),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Passive monitor: event counters plus scoreboard pop on each done pulse.
    always @(negedge clk) begin
        if (RESET) begin
            if (load2)                   n_load_cyc++;
            if (out_ctrl)                n_oc_cyc++;
            if (count_ACK2 && !prev_ack) n_ack_rise++;
            if (done) begin
                n_done_cyc++;
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) chk("done_units", units_done, sb.pop_front());
            end
        end
        prev_ack = count_ACK2;
    end

    task automatic chk_all_zero(input string tag);
        chk(tag, {order_ready, load2, out_ctrl, count_ACK2, busy, done, err, units_done}, 0);
    endtask

    task automatic send_order(input int n);
        int k = 0;
        while (order_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        chk("ready_wait", order_ready, 1);
        n_load_cyc = 0; n_oc_cyc = 0; n_ack_rise = 0; n_done_cyc = 0;
        exp_units = 0;
        order_valid = 1'b1;
        order_units = UNIT_W'(n);
        sb.push_back(n);
        @(negedge clk);
        order_valid = 1'b0;
        chk("load2_after_accept", load2, n != 0);
        chk("busy_after_accept", busy, n != 0);
        chk("ready_low", order_ready, 0);
        chk("units_cleared", units_done, 0);
    endtask

    task automatic unit(input int hi, input int gap, input bit last);
        int k = 0;
        while (out_ctrl !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        chk("run_wait", out_ctrl, 1);
        count2 = 1'b1;
        for (int i = 0; i < hi; i++) begin
            @(negedge clk);
            chk("ack_hi", count_ACK2, 1);
            chk("units_inc", units_done, exp_units + 1);
        end
        exp_units++;
        count2 = 1'b0;
        @(negedge clk);
        chk("ack_fall", count_ACK2, 0);
        if (last) begin
            chk("done_at_fall", done, 1);
            chk("oc_off_at_done", out_ctrl, 0);
        end else begin
            chk("oc_still_on", out_ctrl, 1);
        end
        repeat (gap) @(negedge clk);
    endtask

    task automatic finish_order(input int n);
        @(negedge clk);
        chk("ready_after_done", order_ready, 1);
        chk("done_one_cycle", done, 0);
        chk("busy_idle", busy, 0);
        chk("units_hold", units_done, n);
        chk("done_count", n_done_cyc, 1);
        chk("load2_cycles", n_load_cyc, n != 0);
        chk("ack_handshakes", n_ack_rise, n);
        if (n == 0) chk("oc_never", n_oc_cyc, 0);
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RESET = 1'b0; order_valid = 1'b0; order_units = '0; count2 = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_outputs");
        RESET = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", order_ready, 1);

        // Three units, single-cycle handshakes
        send_order(3);
        unit(1, 0, 0); unit(1, 0, 0); unit(1, 0, 1);
        finish_order(3);

        // Zero-unit order
        send_order(0);
        chk("zero_done", done, 1);
        finish_order(0);

        // Long requests with gaps
        send_order(3);
        unit(5, 2, 0); unit(5, 2, 0); unit(5, 0, 1);
        finish_order(3);

        // Reset during the second unit of four
        send_order(4);
        unit(1, 1, 0);
        count2 = 1'b1;
        @(negedge clk);
        chk("ack_before_reset", count_ACK2, 1);
        #2 RESET = 1'b0;
        #1 chk_all_zero("mid_order_reset");
        count2 = 1'b0;
        sb.delete();
        @(negedge clk);
        RESET = 1'b1;
        @(negedge clk);
        chk("ready_after_rereset", order_ready, 1);
        send_order(2);
        unit(2, 1, 0); unit(2, 0, 1);
        finish_order(2);

        // order_valid during RUN must be ignored
        send_order(3);
        unit(2, 0, 0);
        order_valid = 1'b1; order_units = 8'd7;
        repeat (2) begin
            @(negedge clk);
            chk("ignore_ready", order_ready, 0);
            chk("ignore_units", units_done, 1);
        end
        order_valid = 1'b0;
        unit(1, 0, 0); unit(1, 0, 1);
        finish_order(3);

`ifdef SEQ_TIMEOUT_EN
        send_order(3);
        @(negedge clk);
        chk("tmo_run_start", out_ctrl, 1);
        repeat (19) @(negedge clk);
        chk("tmo_not_yet", err, 0);
        chk("tmo_oc_on", out_ctrl, 1);
        @(negedge clk);
        chk("tmo_err", err, 1);
        chk("tmo_oc_off", out_ctrl, 0);
        chk("tmo_busy", busy, 0);
        @(negedge clk);
        chk("tmo_idle", order_ready, 1);
        chk("tmo_err_sticky", err, 1);
        chk("tmo_no_done", n_done_cyc, 0);
        sb.delete();
        send_order(1);
        chk("tmo_err_cleared", err, 0);
        unit(1, 0, 1);
        finish_order(1);
`else
        send_order(1);
        repeat (40) @(negedge clk);
        chk("notmo_err", err, 0);
        chk("notmo_oc", out_ctrl, 1);
        chk("notmo_busy", busy, 1);
        unit(1, 0, 1);
        finish_order(1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
